// File: rtl/scan_decoder_if.sv
// Bus bundle for scan_decoder: control inputs toward the decoder and
// registered strobe outputs back to the consumer.
interface scan_decoder_if #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) ();
    localparam int OUT_W = 1 << SEL_W;

    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   o;
    logic [SEL_W-1:0]   idx;
    logic               valid;
    logic               wrap;

    modport master (output en, mode, sel, dwell, input o, idx, valid, wrap);
    modport slave  (input en, mode, sel, dwell, output o, idx, valid, wrap);
endinterface

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable and an auto-scan mode.
// DIRECT decodes the external select; SCAN walks every output, holding each
// one for dwell+1 cycles. All outputs come straight from flops.
module scan_decoder #(
    parameter int SEL_W      = 3,
    parameter int DWELL_W    = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic           clk,
    input  logic           rst,
    scan_decoder_if.slave  bus
);
    localparam int OUT_W = 1 << SEL_W;
    localparam logic [OUT_W-1:0] INACT = {OUT_W{(ACTIVE_LOW != 0)}};
    localparam logic [OUT_W-1:0] ONE   = {{(OUT_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(OUT_W - 1);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   o_q, o_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;

    // State register; reset drops any scan position.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state follows en/mode every cycle, never waits for a dwell boundary.
    always_comb begin
        state_d = IDLE;
        if (bus.en) state_d = bus.mode ? SCAN : DIRECT;
    end

    // Next output values, computed for the state being entered.
    always_comb begin
        o_d         = INACT;
        idx_d       = idx_q;
        valid_d     = 1'b0;
        wrap_d      = 1'b0;
        dwell_cnt_d = '0;
        case (state_d)
            DIRECT: begin
                idx_d   = bus.sel;
                valid_d = 1'b1;
            end
            SCAN: begin
                valid_d = 1'b1;
                if (state_q != SCAN) begin
                    // Fresh entry always restarts at index 0 without a wrap pulse.
                    idx_d = '0;
                end else if (dwell_cnt_q >= bus.dwell) begin
                    // dwell is compared live, so lowering it advances promptly.
                    idx_d  = idx_q + SEL_W'(1);
                    wrap_d = (idx_q == LAST);
                end else begin
                    idx_d       = idx_q;
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end
            end
            default: ;
        endcase
        if (valid_d) o_d = INACT ^ (ONE << idx_d);
    end

    // Output and dwell counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q         <= INACT;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
            dwell_cnt_q <= '0;
        end else begin
            o_q         <= o_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            wrap_q      <= wrap_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    assign bus.o     = o_q;
    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: a vector table for reset/DIRECT/disable,
// then hand-written SCAN, mode-switch, reset and active-low sequences.
module tb_scan_decoder;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    scan_decoder_if #(.SEL_W(3), .DWELL_W(8)) bus1 ();
    scan_decoder_if #(.SEL_W(2), .DWELL_W(8)) bus2 ();

    scan_decoder #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    scan_decoder #(.SEL_W(2), .DWELL_W(8), .ACTIVE_LOW(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic       rst;
        logic       en;
        logic       mode;
        logic [2:0] sel;
        logic [7:0] o;
        logic [2:0] idx;
        logic       valid;
        logic       wrap;
        string      name;
    } vec_t;

    vec_t vecs[12];

    task automatic check1(input string name, input logic [7:0] eo, input logic [2:0] ei,
                          input logic ev, input logic ew);
        checks++;
        if (bus1.o !== eo || bus1.idx !== ei || bus1.valid !== ev || bus1.wrap !== ew) begin
            errors++;
            $display("FAIL %s: got o=%h idx=%0d valid=%b wrap=%b, expected o=%h idx=%0d valid=%b wrap=%b",
                     name, bus1.o, bus1.idx, bus1.valid, bus1.wrap, eo, ei, ev, ew);
        end
    endtask

    task automatic check2(input string name, input logic [3:0] eo, input logic [1:0] ei,
                          input logic ev, input logic ew);
        checks++;
        if (bus2.o !== eo || bus2.idx !== ei || bus2.valid !== ev || bus2.wrap !== ew) begin
            errors++;
            $display("FAIL %s: got o=%b idx=%0d valid=%b wrap=%b, expected o=%b idx=%0d valid=%b wrap=%b",
                     name, bus2.o, bus2.idx, bus2.valid, bus2.wrap, eo, ei, ev, ew);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ei;
        // Vector table: reset with SCAN requested, DIRECT sweep, then disable.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, "reset0"};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, "reset1"};
        for (int k = 0; k < 8; k++)
            vecs[2+k] = '{1'b0, 1'b1, 1'b0, k[2:0], 8'(1 << k), k[2:0], 1'b1, 1'b0, "direct"};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 1'b0, 1'b0, "disable0"};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 1'b0, 1'b0, "disable1"};

        rst = 1'b1;
        bus1.en = 1'b0; bus1.mode = 1'b0; bus1.sel = '0; bus1.dwell = '0;
        bus2.en = 1'b1; bus2.mode = 1'b1; bus2.sel = '0; bus2.dwell = '0;

        for (int i = 0; i < 12; i++) begin
            rst       = vecs[i].rst;
            bus1.en   = vecs[i].en;
            bus1.mode = vecs[i].mode;
            bus1.sel  = vecs[i].sel;
            if (i == 2) bus2.en = 1'b0;
            step();
            check1(vecs[i].name, vecs[i].o, vecs[i].idx, vecs[i].valid, vecs[i].wrap);
            if (i < 2) check2("reset_al", 4'b1111, 2'd0, 1'b0, 1'b0);
        end

        // SCAN with dwell=2: each index held 3 cycles, period 24, wrap on second idx 0.
        bus1.mode = 1'b1; bus1.dwell = 8'd2; bus1.en = 1'b1;
        for (int t = 0; t < 27; t++) begin
            step();
            ei = (t / 3) % 8;
            check1("scan_dwell2", 8'(1 << ei), ei[2:0], 1'b1, t == 24);
        end
        bus1.en = 1'b0;
        step();
        check1("scan_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // SCAN with dwell=0: one step per cycle, wrap every 8 cycles.
        bus1.dwell = 8'd0; bus1.en = 1'b1;
        for (int t = 0; t < 18; t++) begin
            step();
            ei = t % 8;
            check1("scan_dwell0", 8'(1 << ei), ei[2:0], 1'b1, t == 8 || t == 16);
        end

        // Mid-scan switch to DIRECT, back to SCAN (restart, no wrap), then reset at idx 3.
        bus1.en = 1'b0;
        step();
        bus1.en = 1'b1;
        for (int t = 0; t < 6; t++) begin
            step();
            check1("scan_to5", 8'(1 << t), t[2:0], 1'b1, 1'b0);
        end
        bus1.mode = 1'b0; bus1.sel = 3'd2;
        step();
        check1("scan_to_direct", 8'h04, 3'd2, 1'b1, 1'b0);
        bus1.mode = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            check1("direct_to_scan", 8'(1 << t), t[2:0], 1'b1, 1'b0);
        end
        rst = 1'b1;
        step();
        check1("mid_scan_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check1("scan_after_reset", 8'h01, 3'd0, 1'b1, 1'b0);
        bus1.en = 1'b0;

        // Active-low, 4 outputs.
        bus2.en = 1'b1; bus2.mode = 1'b0; bus2.sel = 2'd1;
        step();
        check2("al_direct", 4'b1101, 2'd1, 1'b1, 1'b0);
        bus2.en = 1'b0;
        step();
        check2("al_disable", 4'b1111, 2'd1, 1'b0, 1'b0);
        bus2.en = 1'b1; bus2.mode = 1'b1; bus2.dwell = 8'd5;
        for (int t = 0; t < 4; t++) begin
            step();
            check2("al_scan_dwell5", 4'b1110, 2'd0, 1'b1, 1'b0);
        end
        // dwell_cnt is 3 here; lowering dwell to 1 advances on the next edge.
        bus2.dwell = 8'd1;
        step();
        check2("al_dwell_lowered", 4'b1101, 2'd1, 1'b1, 1'b0);
        step();
        check2("al_dwell1_hold", 4'b1101, 2'd1, 1'b1, 1'b0);
        step();
        check2("al_dwell1_step", 4'b1011, 2'd2, 1'b1, 1'b0);
        bus2.dwell = 8'd0;
        step();
        check2("al_step3", 4'b0111, 2'd3, 1'b1, 1'b0);
        step();
        check2("al_wrap", 4'b1110, 2'd0, 1'b1, 1'b1);
        step();
        check2("al_after_wrap", 4'b1101, 2'd1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
